mcp_send_rr_arb: RTL and testbench
==================================

MCP_SEND_RR_ARB -- requirements
Module: mcp_send_rr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter DWIDTH, default 32, payload width; matches the MCP sender data width.
REQ-003 Parameter TIMEOUT_CYC, default 1024, maximum BUSY cycles before error; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all logic posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  NUM_REQ  per-requester request; held until the matching req_ready.
REQ-007 req_data  in  NUM_REQ*DWIDTH  payload; requester i at bits [i*DWIDTH +: DWIDTH].
REQ-008 req_ready  out  NUM_REQ  one-hot 1-cycle accept pulse to the winning requester.
REQ-009 aready  in  1  ready from the MCP sender in the same clock domain.
REQ-010 asend  out  1  send pulse to the MCP sender.
REQ-011 adata_in  out  DWIDTH  payload to the MCP sender.
REQ-012 busy  out  1  high when state != IDLE.
REQ-013 cur_owner  out  $clog2(NUM_REQ)  index of the last granted requester.
REQ-014 xfer_cnt  out  16  count of completed sends; wraps 0xFFFF->0.
REQ-015 err_clr  in  1  clears err_timeout.
REQ-016 err_timeout  out  1  sticky timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, BUSY, all registered.
REQ-018 IDLE with |req_valid: winner selected round-robin; req_ready[winner]=1 that cycle; req_data[winner] captured into adata_in; cur_owner updated; next state ISSUE.
REQ-019 Round-robin: search starts at (cur_owner+1) mod NUM_REQ, ascending with wrap; the first set req_valid wins.
REQ-020 IDLE with no req_valid: no req_ready, remain IDLE.
REQ-021 ISSUE: asend = aready (combinational); when aready=1, next state BUSY and xfer_cnt increments; when aready=0, hold ISSUE with adata_in stable.
REQ-022 BUSY: remain until aready=1, then IDLE; asend=0 throughout.
REQ-023 Minimum spacing between two asend pulses is 3 cycles (ISSUE, BUSY>=1, IDLE).
REQ-024 adata_in SHALL change only on an IDLE grant.
REQ-025 req_ready SHALL never assert outside IDLE and is at most one-hot.
REQ-026 A requester dropping req_valid before grant is legal and loses its turn; no state change.
REQ-027 Timeout counter clears on BUSY entry and increments each BUSY cycle; when TIMEOUT_CYC != 0 and the count reaches TIMEOUT_CYC, err_timeout is set and the FSM stays in BUSY waiting for aready.
REQ-028 err_clr clears err_timeout; if set and clear occur in the same cycle, set wins.
REQ-029 The timeout counter saturates; it does not wrap.

Reset
REQ-030 rst=1 at a clock edge: state=IDLE, cur_owner=NUM_REQ-1 (requester 0 has first priority), adata_in=0, xfer_cnt=0, err_timeout=0, timeout counter=0.
REQ-031 During rst: asend=0, req_ready=0, busy=0; rst overrides all other inputs.
REQ-032 rst in ISSUE or BUSY abandons the transfer with no asend and no xfer_cnt increment; the requester already saw req_ready, so the loss is accepted.

Verification
REQ-033 Reset, then req_valid=4'b0001, data 0xA5, aready=1: req_ready[0] at cycle 1; asend=1 with adata_in=0xA5 at cycle 2; xfer_cnt=1.
REQ-034 All four req_valid held high, sender model drops aready for 2 cycles after each send: grant order 0,1,2,3,0; xfer_cnt=5.
REQ-035 req_valid=4'b1010 after a grant to 3: next winner 1, then 3 (wrap).
REQ-036 aready=0 during ISSUE for 5 cycles: asend stays 0 and adata_in stable; asend pulses once when aready rises; only one xfer_cnt increment.
REQ-037 TIMEOUT_CYC=8, aready held 0 in BUSY: err_timeout=1 after 8 BUSY cycles; err_clr pulse clears it; aready=1 then returns the FSM to IDLE.
REQ-038 rst asserted in BUSY: next cycle all outputs at reset values; the next grant goes to requester 0.

Source files
------------

// File: rtl/mcp_send_rr_arb.sv
// mcp_send_rr_arb
// Round-robin arbiter that funnels NUM_REQ requesters into a single MCP
// sender. A winner is picked in IDLE, its payload is held in adata_in while
// the sender is offered one send pulse, and the FSM then waits in BUSY
// until the sender reports ready again. A BUSY watchdog raises a sticky
// error flag if the sender stays busy for too long.

module mcp_send_rr_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DWIDTH      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       aready,
  output logic                       asend,
  output logic [DWIDTH-1:0]          adata_in,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_owner,
  output logic [15:0]                xfer_cnt,
  input  logic                       err_clr,
  output logic                       err_timeout
);

  localparam int OW = $clog2(NUM_REQ);
  // The watchdog counter is just wide enough to hold TIMEOUT_CYC; with the
  // timeout disabled a single bit is kept so the logic stays well formed.
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TO_MAX  = '1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t            state;
  logic [TW-1:0]     to_cnt;
  logic              win_found;
  logic [OW-1:0]     win_idx;
  logic [OW-1:0]     cand_idx;
  int                cand;
  logic              grant;
  logic              err_set;

  // Round-robin search: start one past the last owner and take the first
  // active request, wrapping around so the last owner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(cur_owner) + k) % NUM_REQ;
      cand_idx = OW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Handshake outputs follow the registered state; reset masks them so a
  // reset cycle never leaks an accept or a send.
  always_comb begin
    grant     = (state == IDLE) && win_found && !rst;
    req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
    asend     = (state == ISSUE) && aready && !rst;
    busy      = (state != IDLE) && !rst;
    err_set   = (TIMEOUT_CYC != 0) && (state == BUSY) && (to_cnt == TO_LAST);
  end

  // Main FSM: grant and capture in IDLE, offer one send in ISSUE, then wait
  // out the sender in BUSY while the watchdog counts up and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_owner <= OW'(NUM_REQ - 1);
      adata_in  <= '0;
      xfer_cnt  <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            cur_owner <= win_idx;
            adata_in  <= req_data[int'(win_idx)*DWIDTH +: DWIDTH];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (aready) begin
            state    <= BUSY;
            xfer_cnt <= xfer_cnt + 16'd1;
            to_cnt   <= '0;
          end
        end
        BUSY: begin
          if (aready) begin
            state <= IDLE;
          end
          if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a new timeout in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (err_set) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcp_send_rr_arb.sv
// tb_mcp_send_rr_arb
// Directed bench for the round-robin MCP send arbiter. Expected grants and
// sends are queued as stimulus is issued; a negedge monitor pops and checks
// them whenever the DUT raises req_ready or asend.

module tb_mcp_send_rr_arb;

  localparam int NUM_REQ     = 4;
  localparam int DWIDTH      = 32;
  localparam int TIMEOUT_CYC = 8;
  localparam int WAIT_LIMIT  = 200;

  typedef struct packed {
    logic [1:0]  owner;
    logic [31:0] data;
  } send_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DWIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      aready;
  logic                      asend;
  logic [DWIDTH-1:0]         adata_in;
  logic                      busy;
  logic [1:0]                cur_owner;
  logic [15:0]               xfer_cnt;
  logic                      err_clr;
  logic                      err_timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  int grant_count  = 0;
  int send_count   = 0;
  int exp_sends    = 0;
  int grant_target = 0;
  int drop_left    = 0;
  bit grant_stop   = 1'b0;
  bit drop_model   = 1'b0;

  logic [NUM_REQ-1:0] one_shot;
  logic [NUM_REQ-1:0] last_ready;
  logic               last_send;
  logic [NUM_REQ-1:0] grant_q[$];
  send_t              send_q[$];
  logic [NUM_REQ-1:0] mon_grant;
  send_t              mon_send;

  mcp_send_rr_arb #(
    .NUM_REQ    (NUM_REQ),
    .DWIDTH     (DWIDTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .aready     (aready),
    .asend      (asend),
    .adata_in   (adata_in),
    .busy       (busy),
    .cur_owner  (cur_owner),
    .xfer_cnt   (xfer_cnt),
    .err_clr    (err_clr),
    .err_timeout(err_timeout)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  function automatic logic [31:0] req_word(input int i);
    case (i)
      0:       return 32'h0000_00A5;
      1:       return 32'h1111_1111;
      2:       return 32'h2222_2222;
      default: return 32'h3333_3333;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Queue the grant and the send that requester i should eventually produce
  task automatic expect_transfer(input int i);
    grant_q.push_back(4'b0001 << i);
    send_q.push_back({2'(i), req_word(i)});
    exp_sends++;
  endtask

  // Advance one cycle, then update the requester and sender models
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(last_ready & one_shot);
    if (grant_stop && grant_count >= grant_target) req_valid = '0;
    if (drop_model) begin
      if (last_send) drop_left = 2;
      if (drop_left > 0) begin
        aready = 1'b0;
        drop_left--;
      end else begin
        aready = 1'b1;
      end
    end
  endtask

  task automatic wait_sample();
    @(negedge clk);
  endtask

  // Run until all queued sends have happened and the FSM is back in IDLE
  task automatic run_until_idle();
    int n;
    n = 0;
    while ((send_count < exp_sends || busy) && n < WAIT_LIMIT) begin
      applyStimulus();
      n++;
    end
    checkOutput("wait_bound", 64'(n < WAIT_LIMIT), 64'd1);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    aready    = 1'b0;
    err_clr   = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: compare every grant and every send against the queues
  always @(negedge clk) begin
    if (rst) begin
      last_ready = '0;
      last_send  = 1'b0;
    end else begin
      last_ready = req_ready;
      last_send  = asend;
      if (req_ready != '0) begin
        grant_count++;
        if (grant_q.size() == 0) begin
          checkOutput("unexpected_grant", 64'(req_ready), 64'd0);
        end else begin
          mon_grant = grant_q.pop_front();
          checkOutput("grant", 64'(req_ready), 64'(mon_grant));
        end
      end
      if (asend) begin
        send_count++;
        if (send_q.size() == 0) begin
          checkOutput("unexpected_send", 64'(adata_in), 64'd0);
        end else begin
          mon_send = send_q.pop_front();
          checkOutput("send_data", 64'(adata_in), 64'(mon_send.data));
          checkOutput("send_owner", 64'(cur_owner), 64'(mon_send.owner));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_data = {req_word(3), req_word(2), req_word(1), req_word(0)};
    one_shot = '1;

    // Reset with every input active: reset must mask all handshakes
    rst       = 1'b1;
    req_valid = 4'b1111;
    aready    = 1'b1;
    err_clr   = 1'b0;
    applyStimulus();
    applyStimulus();
    wait_sample();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_asend", 64'(asend), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    applyStimulus();
    rst       = 1'b0;
    req_valid = '0;
    aready    = 1'b0;
    wait_sample();
    checkOutput("rst_owner", 64'(cur_owner), 64'd3);
    checkOutput("rst_adata", 64'(adata_in), 64'd0);
    checkOutput("rst_xfer", 64'(xfer_cnt), 64'd0);
    checkOutput("rst_err", 64'(err_timeout), 64'd0);

    // Single transfer from requester 0
    applyStimulus();
    req_valid = 4'b0001;
    aready    = 1'b1;
    expect_transfer(0);
    wait_sample();
    checkOutput("t1_ready_cycle1", 64'(req_ready), 64'h1);
    applyStimulus();
    wait_sample();
    checkOutput("t1_asend_cycle2", 64'(asend), 64'd1);
    checkOutput("t1_adata_cycle2", 64'(adata_in), 64'hA5);
    run_until_idle();
    checkOutput("t1_xfer", 64'(xfer_cnt), 64'd1);

    // All four requesting continuously, sender drops ready 2 cycles per send
    do_reset();
    one_shot     = '0;
    req_valid    = 4'b1111;
    aready       = 1'b1;
    drop_left    = 0;
    drop_model   = 1'b1;
    grant_stop   = 1'b1;
    grant_target = grant_count + 5;
    expect_transfer(0);
    expect_transfer(1);
    expect_transfer(2);
    expect_transfer(3);
    expect_transfer(0);
    run_until_idle();
    grant_stop = 1'b0;
    drop_model = 1'b0;
    one_shot   = '1;
    checkOutput("t2_xfer", 64'(xfer_cnt), 64'd5);

    // Grant to 3, then 1010 must go to 1 and then wrap to 3
    aready    = 1'b1;
    req_valid = 4'b1000;
    expect_transfer(3);
    run_until_idle();
    req_valid = 4'b1010;
    expect_transfer(1);
    expect_transfer(3);
    run_until_idle();
    checkOutput("t3_xfer", 64'(xfer_cnt), 64'd8);
    checkOutput("t3_owner", 64'(cur_owner), 64'd3);

    // Sender not ready during ISSUE for 5 cycles
    req_valid = 4'b0100;
    aready    = 1'b0;
    expect_transfer(2);
    applyStimulus();
    for (int c = 0; c < 5; c++) begin
      wait_sample();
      checkOutput("t4_hold_asend", 64'(asend), 64'd0);
      checkOutput("t4_hold_adata", 64'(adata_in), 64'(req_word(2)));
      checkOutput("t4_hold_busy", 64'(busy), 64'd1);
      applyStimulus();
    end
    aready = 1'b1;
    wait_sample();
    checkOutput("t4_asend", 64'(asend), 64'd1);
    run_until_idle();
    checkOutput("t4_xfer", 64'(xfer_cnt), 64'd9);

    // Sender stuck in BUSY: timeout after 8 cycles, clear, then release
    req_valid = 4'b0001;
    aready    = 1'b1;
    expect_transfer(0);
    applyStimulus();
    applyStimulus();
    aready = 1'b0;
    repeat (7) applyStimulus();
    wait_sample();
    checkOutput("t5_err_7cyc", 64'(err_timeout), 64'd0);
    applyStimulus();
    wait_sample();
    checkOutput("t5_err_8cyc", 64'(err_timeout), 64'd1);
    checkOutput("t5_busy", 64'(busy), 64'd1);
    applyStimulus();
    err_clr = 1'b1;
    applyStimulus();
    err_clr = 1'b0;
    wait_sample();
    checkOutput("t5_err_cleared", 64'(err_timeout), 64'd0);
    checkOutput("t5_still_busy", 64'(busy), 64'd1);
    applyStimulus();
    aready = 1'b1;
    run_until_idle();
    checkOutput("t5_err_final", 64'(err_timeout), 64'd0);
    checkOutput("t5_xfer", 64'(xfer_cnt), 64'd10);

    // Reset while BUSY, then requester 0 must win first
    req_valid = 4'b0010;
    aready    = 1'b1;
    expect_transfer(1);
    applyStimulus();
    applyStimulus();
    aready = 1'b0;
    applyStimulus();
    wait_sample();
    checkOutput("t6_busy_pre", 64'(busy), 64'd1);
    applyStimulus();
    rst       = 1'b1;
    req_valid = 4'b1111;
    aready    = 1'b1;
    wait_sample();
    checkOutput("t6_rst_ready", 64'(req_ready), 64'd0);
    checkOutput("t6_rst_asend", 64'(asend), 64'd0);
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    applyStimulus();
    rst       = 1'b0;
    req_valid = '0;
    aready    = 1'b0;
    wait_sample();
    checkOutput("t6_owner", 64'(cur_owner), 64'd3);
    checkOutput("t6_xfer", 64'(xfer_cnt), 64'd0);
    checkOutput("t6_adata", 64'(adata_in), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    applyStimulus();
    req_valid = 4'b0011;
    aready    = 1'b1;
    expect_transfer(0);
    expect_transfer(1);
    run_until_idle();
    checkOutput("t6_xfer_after", 64'(xfer_cnt), 64'd2);

    checkOutput("grant_q_drained", 64'(grant_q.size()), 64'd0);
    checkOutput("send_q_drained", 64'(send_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
